inventory_store: RTL and testbench

- Responder end of the inventory add/remove interface: holds one 8-bit quantity per 8-bit item code.
- Serves one request at a time by read-modify-write on an internal synchronous RAM.
- Returns the resulting quantity plus a status code to the requesting controller over a valid/ready response channel.
- Clears all storage after every reset by sweeping the RAM.

---
 rtl/inventory_store.sv | 172 +++++++++++++++++
 tb/tb_inventory_store.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/inventory_store.sv
// Per-item quantity store. Each request is served as one read-modify-write on an internal RAM.
// The RAM is cleared by a full address sweep after every reset.
//
// state | meaning
// INIT  | sweeping zeros into the RAM, one address per cycle
// IDLE  | ready to accept a request; RAM read issued on accept
// READ  | RAM read data settling into rd_data_q
// CALC  | new quantity/status computed, write-back performed
// RESP  | response presented until the requester takes it
module inventory_store #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_code,
  input  logic [DATA_W-1:0] req_quant,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_quant,
  output logic [1:0]        resp_status,
  output logic              init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] OP_QUERY = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_REM   = 2'b10;
  localparam logic [1:0] OP_OVR   = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_SAT   = 2'b01;
  localparam logic [1:0] ST_INSUF = 2'b10;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_CALC,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] code_q, code_d;
  logic [DATA_W-1:0] quant_q, quant_d;
  logic [DATA_W-1:0] resp_quant_q, resp_quant_d;
  logic [1:0]        resp_status_q, resp_status_d;
  logic              init_done_q, init_done_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W:0]   sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      op_q          <= OP_QUERY;
      code_q        <= '0;
      quant_q       <= '0;
      resp_quant_q  <= '0;
      resp_status_q <= ST_OK;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      code_q        <= code_d;
      quant_q       <= quant_d;
      resp_quant_q  <= resp_quant_d;
      resp_status_q <= resp_status_d;
      init_done_q   <= init_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    code_d        = code_q;
    quant_d       = quant_q;
    resp_quant_d  = resp_quant_q;
    resp_status_d = resp_status_q;
    init_done_d   = init_done_q;
    wr_en         = 1'b0;
    wr_addr       = cnt_q;
    wr_data       = '0;
    rd_en         = 1'b0;
    sum           = {1'b0, rd_data_q} + {1'b0, quant_q};

    case (state_q)
      S_INIT: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          code_d  = req_code;
          quant_d = req_quant;
          rd_en   = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_CALC;
      S_CALC: begin
        wr_addr       = code_q;
        resp_status_d = ST_OK;
        resp_quant_d  = rd_data_q;
        case (op_q)
          OP_ADD: begin
            wr_en = 1'b1;
            if (sum[DATA_W]) begin
              wr_data       = '1;
              resp_status_d = ST_SAT;
            end else begin
              wr_data = sum[DATA_W-1:0];
            end
            resp_quant_d = wr_data;
          end
          OP_REM: begin
            // Insufficient stock leaves the RAM untouched and reports what is there.
            if (quant_q > rd_data_q) begin
              resp_status_d = ST_INSUF;
            end else begin
              wr_en        = 1'b1;
              wr_data      = rd_data_q - quant_q;
              resp_quant_d = wr_data;
            end
          end
          OP_OVR: begin
            wr_en        = 1'b1;
            wr_data      = quant_q;
            resp_quant_d = quant_q;
          end
          default: ;
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[req_code];
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_quant  = resp_quant_q;
  assign resp_status = resp_status_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_inventory_store.sv
// Randomized bench for inventory_store. Expected responses come from a plain per-code quantity array
// updated with the add/remove/overwrite rules.
module tb_inventory_store;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_code = 8'h00;
  logic [7:0] req_quant = 8'h00;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic [7:0] resp_quant;
  logic [1:0] resp_status;
  logic       init_done;

  int n_chk = 0;
  int n_fail = 0;
  int model [256];

  inventory_store #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_code(req_code), .req_quant(req_quant),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quant(resp_quant), .resp_status(resp_status),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    int cyc;
    int early;
    rst = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_quant", resp_quant, 0);
    chk("rst_resp_status", resp_status, 0);
    chk("rst_init_done", init_done, 0);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 0;
    cyc = 0;
    early = 0;
    while (!init_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (req_ready && !init_done) early++;
      if (cyc < 256 && req_ready) early++;
    end
    chk("sweep_len", cyc, 256);
    chk("sweep_ready_early", early, 0);
    chk("ready_after_sweep", req_ready, 1);
  endtask

  // One full transaction; stall holds resp_ready low that many cycles, junk drives an ignored request meanwhile.
  task automatic send(input int op, input int code, input int q, input int stall, input bit junk);
    int m, exp_q, exp_s, cyc;
    m = model[code];
    exp_s = 0;
    case (op)
      0: exp_q = m;
      1: if (m + q > 255) begin exp_q = 255; exp_s = 1; end else exp_q = m + q;
      2: if (q > m) begin exp_q = m; exp_s = 2; end else exp_q = m - q;
      default: exp_q = q;
    endcase
    model[code] = exp_q;

    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_op = 2'(op);
    req_code = 8'(code);
    req_quant = 8'(q);
    resp_ready = (stall == 0);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 3);
    chk("resp_quant", resp_quant, exp_q);
    chk("resp_status", resp_status, exp_s);

    if (stall > 0) begin
      if (junk) begin
        req_valid = 1'b1;
        req_op = 2'b11;
        req_code = 8'(code);
        req_quant = 8'(~q);
      end
      repeat (stall) begin
        @(negedge clk);
        chk("stall_valid", resp_valid, 1);
        chk("stall_quant", resp_quant, exp_q);
        chk("stall_status", resp_status, exp_s);
        chk("stall_ready", req_ready, 0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(negedge clk);
    chk("resp_drop", resp_valid, 0);
    chk("idle_ready", req_ready, 1);
    chk("quant_hold", resp_quant, exp_q);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    #2;
    do_reset();

    send(0, 8'h05, 0, 0, 0);
    send(1, 8'h10, 100, 0, 0);
    send(1, 8'h10, 100, 0, 0);
    send(1, 8'h10, 100, 0, 0);
    send(0, 8'h10, 0, 0, 0);
    send(3, 8'h20, 30, 0, 0);
    send(2, 8'h20, 40, 0, 0);
    send(0, 8'h20, 0, 0, 0);
    send(2, 8'h20, 30, 0, 0);
    send(0, 8'h20, 0, 0, 0);

    send(3, 8'h40, 77, 5, 1);
    send(0, 8'h40, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      int op, code, q, st;
      op = $urandom_range(0, 3);
      code = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      q = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 60);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      send(op, code, q, st, 1'b0);
    end
    for (int c = 0; c < 8; c++) send(0, c, 0, 0, 0);

    // Reset while an add to 0x30 is in CALC: no response, and the sweep clears everything.
    send(3, 8'h30, 9, 0, 0);
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b1;
    req_op = 2'b01;
    req_code = 8'h30;
    req_quant = 8'd50;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_init_done", init_done, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    do_reset();
    send(0, 8'h30, 0, 0, 0);
    send(0, 8'h10, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
